// File: rtl/cdi_bus_pkg.sv
// Shared types and constants for the CD-i CPU-side bus fabric.
package cdi_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACTIVE = 3'd1,
    ACK    = 3'd2,
    ERR    = 3'd3,
    DONE   = 3'd4
  } bus_state_t;

  // Wait count that hands cycle termination to the slave's own acknowledge.
  localparam logic [3:0] WAIT_EXT    = 4'hF;
  localparam int         TIMEOUT_DEF = 255;

endpackage

// File: rtl/cdi_bus_match.sv
// Priority address decoder: lowest-index region whose masked address equals its base wins.
module cdi_bus_match #(
  parameter int NUM_SLAVES = 4,
  parameter int SW         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [23:0]                 addr_byte,
  input  logic [NUM_SLAVES-1:0][23:0] base,
  input  logic [NUM_SLAVES-1:0][23:0] mask,
  output logic                        hit,
  output logic [SW-1:0]               sel
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_byte & mask[i]) == base[i]) begin
        hit = 1'b1;
        sel = SW'(i);
      end
    end
  end

endmodule

// File: rtl/cdi_bus_fabric.sv
// CPU-side bus fabric: region decode, wait states / external ack, read-data mux,
// bus error on unmapped access or timeout, and clean abort when the strobe drops.
module cdi_bus_fabric
  import cdi_bus_pkg::*;
#(
  parameter int                          NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES-1:0][23:0] BASE       = '0,
  parameter logic [NUM_SLAVES-1:0][23:0] MASK       = '0,
  parameter logic [NUM_SLAVES-1:0][3:0]  WAITS      = '0,
  parameter int                          TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [23:1]                 cpu_addr,
  input  logic                        cpu_as,
  input  logic                        cpu_uds,
  input  logic                        cpu_lds,
  input  logic                        cpu_write_strobe,
  output logic [15:0]                 cpu_din,
  output logic                        cpu_bus_ack,
  output logic                        cpu_bus_err,
  output logic [NUM_SLAVES-1:0]       slv_cs,
  input  logic [NUM_SLAVES-1:0]       slv_ack,
  input  logic [NUM_SLAVES-1:0][15:0] slv_dout,
  output logic [23:0]                 err_addr
);

  localparam int             SW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int             CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  bus_state_t    state, state_nx;
  logic [SW-1:0] sel, dec_sel;
  logic          dec_hit;
  logic [3:0]    wcnt;
  logic [CW-1:0] tcnt;
  logic [23:0]   addr_byte;
  logic          req, ext, acked, tmo;

  // Write direction is routed to slaves outside this block.
  logic unused_wr;
  assign unused_wr = cpu_write_strobe;

  assign addr_byte = {cpu_addr, 1'b0};
  assign req       = cpu_as && (cpu_uds || cpu_lds);

  cdi_bus_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .SW         (SW)
  ) u_match (
    .addr_byte (addr_byte),
    .base      (BASE),
    .mask      (MASK),
    .hit       (dec_hit),
    .sel       (dec_sel)
  );

  always_comb begin
    state_nx = state;
    ext      = (WAITS[sel] == WAIT_EXT);
    acked    = ext ? slv_ack[sel] : (wcnt == 4'd0);
    tmo      = (tcnt == TO_LAST);
    case (state)
      IDLE:   if (req) state_nx = dec_hit ? ACTIVE : ERR;
      // Strobe loss beats everything; an ack beats a timeout in the same cycle.
      ACTIVE: begin
        if (!cpu_as)    state_nx = IDLE;
        else if (acked) state_nx = ACK;
        else if (tmo)   state_nx = ERR;
      end
      ACK:    state_nx = DONE;
      ERR:    state_nx = DONE;
      DONE:   if (!cpu_as) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= '0;
      wcnt     <= '0;
      tcnt     <= '0;
      cpu_din  <= '0;
      err_addr <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req && dec_hit) begin
            sel  <= dec_sel;
            wcnt <= WAITS[dec_sel];
            tcnt <= '0;
          end else if (req) begin
            err_addr <= addr_byte;
          end
        end
        ACTIVE: begin
          if (cpu_as) begin
            tcnt <= tcnt + 1'b1;
            if (!ext && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
            if (acked)    cpu_din  <= slv_dout[sel];
            else if (tmo) err_addr <= addr_byte;
          end
        end
        default: ;
      endcase
    end
  end

  // Responses and selects decode straight from flops, never from inputs.
  assign cpu_bus_ack = (state == ACK);
  assign cpu_bus_err = (state == ERR);

  always_comb begin
    slv_cs = '0;
    if (state == ACTIVE || state == ACK) slv_cs[sel] = 1'b1;
  end

endmodule

// File: tb/tb_cdi_bus_fabric.sv
// Bench for cdi_bus_fabric: transaction-timing reference model checked every cycle,
// directed literal scenarios, then randomized strobes/acks/resets.
module tb_cdi_bus_fabric;

  localparam int NS  = 4;
  localparam int TMO = 8;
  localparam logic [NS-1:0][23:0] P_BASE  = {24'h000000, 24'h400000, 24'h310000, 24'h000000};
  localparam logic [NS-1:0][23:0] P_MASK  = {24'hF00000, 24'hFF0000, 24'hFF0000, 24'hF80000};
  localparam logic [NS-1:0][3:0]  P_WAITS = {4'd3, 4'd5, 4'hF, 4'd0};

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [23:1]         cpu_addr = '0;
  logic                cpu_as = 1'b0, cpu_uds = 1'b0, cpu_lds = 1'b0, cpu_write_strobe = 1'b0;
  logic [15:0]         cpu_din;
  logic                cpu_bus_ack, cpu_bus_err;
  logic [NS-1:0]       slv_cs;
  logic [NS-1:0]       slv_ack = '0;
  logic [NS-1:0][15:0] slv_dout = '0;
  logic [23:0]         err_addr;

  cdi_bus_fabric #(
    .NUM_SLAVES (NS), .BASE (P_BASE), .MASK (P_MASK), .WAITS (P_WAITS), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .reset (reset), .cpu_addr (cpu_addr), .cpu_as (cpu_as),
    .cpu_uds (cpu_uds), .cpu_lds (cpu_lds), .cpu_write_strobe (cpu_write_strobe),
    .cpu_din (cpu_din), .cpu_bus_ack (cpu_bus_ack), .cpu_bus_err (cpu_bus_err),
    .slv_cs (slv_cs), .slv_ack (slv_ack), .slv_dout (slv_dout), .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  int nvec = 0, nmis = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int find_region(input logic [23:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & P_MASK[i]) == P_BASE[i]) return i;
    return -1;
  endfunction

  // Reference model: a transaction is timed from the cycle its request is seen.
  bit          m_act = 0, m_ack = 0, m_err = 0, m_blk = 0;
  int          m_r = 0, m_t0 = 0, cyc = 0;
  logic [15:0] m_din = '0;
  logic [23:0] m_eaddr = '0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_act = 0; m_ack = 0; m_err = 0; m_blk = 0; m_din = '0; m_eaddr = '0;
    end else begin
      bit n_act, n_ack, n_err, n_blk;
      int k, r;
      n_act = 0; n_ack = 0; n_err = 0; n_blk = m_blk;
      if (m_act) begin
        k = cyc - m_t0;
        if (!cpu_as) begin
          n_act = 0;
        end else if (P_WAITS[m_r] == 4'hF ? slv_ack[m_r] : (k == int'(P_WAITS[m_r]) + 1)) begin
          n_ack = 1; m_din = slv_dout[m_r];
        end else if (k == TMO) begin
          n_err = 1; m_eaddr = {cpu_addr, 1'b0};
        end else begin
          n_act = 1;
        end
      end else if (m_ack || m_err) begin
        n_blk = 1;
      end else if (m_blk) begin
        if (!cpu_as) n_blk = 0;
      end else if (cpu_as && (cpu_uds || cpu_lds)) begin
        r = find_region({cpu_addr, 1'b0});
        if (r < 0) begin
          n_err = 1; m_eaddr = {cpu_addr, 1'b0};
        end else begin
          n_act = 1; m_r = r; m_t0 = cyc;
        end
      end
      m_act = n_act; m_ack = n_ack; m_err = n_err; m_blk = n_blk;
    end
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      logic [NS-1:0] e_cs;
      e_cs = '0;
      if (m_act || m_ack) e_cs[m_r] = 1'b1;
      chk("ack", 32'(cpu_bus_ack), 32'(m_ack));
      chk("err", 32'(cpu_bus_err), 32'(m_err));
      chk("cs", 32'(slv_cs), 32'(e_cs));
      chk("din", 32'(cpu_din), 32'(m_din));
      chk("err_addr", 32'(err_addr), 32'(m_eaddr));
    end
  end

  logic [NS-1:0] cs_log [0:31];

  // Start a request, optionally pulse slv_ack[1] or drop the strobe, record responses.
  task automatic run_req(input logic [23:0] a, input int ack_k, input int drop_k, input int ncyc,
                         output int rc, output bit re, output int nresp);
    rc = -1; re = 0; nresp = 0;
    @(posedge clk); #1;
    cpu_addr = a[23:1]; cpu_as = 1; cpu_uds = 1; cpu_lds = 1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      slv_ack = (c == ack_k) ? 4'b0010 : 4'b0000;
      if (c == drop_k) cpu_as = 0;
      @(negedge clk);
      cs_log[c] = slv_cs;
      if (cpu_bus_ack || cpu_bus_err) begin
        nresp++;
        if (rc < 0) begin rc = c; re = cpu_bus_err; end
      end
    end
    @(posedge clk); #1;
    cpu_as = 0; cpu_uds = 0; cpu_lds = 0; slv_ack = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  function automatic logic [23:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return {5'b00000, 19'($urandom())};
      1:       return {8'h31, 16'($urandom())};
      2:       return {8'h40, 16'($urandom())};
      3:       return {5'b00001, 19'($urandom())};
      4:       return {8'h60, 16'($urandom())};
      default: return 24'($urandom());
    endcase
  endfunction

  initial begin
    int rc, nr;
    bit re;
    logic [23:0] a;
    slv_dout = {16'h0F0F, 16'h5A5A, 16'hBEEF, 16'h1234};
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk_on = 1;
    @(negedge clk);
    chk("rst_ack", 32'(cpu_bus_ack), 32'd0);
    chk("rst_err", 32'(cpu_bus_err), 32'd0);
    chk("rst_cs", 32'(slv_cs), 32'd0);
    chk("rst_din", 32'(cpu_din), 32'd0);
    chk("rst_eaddr", 32'(err_addr), 32'd0);

    run_req(24'h000010, -1, -1, 8, rc, re, nr);
    chk("r0_ack_cycle", 32'(rc), 32'd2);
    chk("r0_is_err", 32'(re), 32'd0);
    chk("r0_din", 32'(cpu_din), 32'h1234);
    chk("r0_cs_c1", 32'(cs_log[1]), 32'h1);
    chk("r0_cs_c2", 32'(cs_log[2]), 32'h1);
    chk("r0_cs_c3", 32'(cs_log[3]), 32'h0);
    chk("r0_one_resp", 32'(nr), 32'd1);

    run_req(24'h310040, 5, -1, 10, rc, re, nr);
    chk("ext_ack_cycle", 32'(rc), 32'd6);
    chk("ext_is_err", 32'(re), 32'd0);
    chk("ext_din", 32'(cpu_din), 32'hBEEF);

    run_req(24'h600000, -1, -1, 6, rc, re, nr);
    chk("unmap_cycle", 32'(rc), 32'd1);
    chk("unmap_is_err", 32'(re), 32'd1);
    chk("unmap_eaddr", 32'(err_addr), 32'h600000);
    chk("unmap_cs", 32'(cs_log[1]), 32'h0);

    run_req(24'h310020, -1, -1, 14, rc, re, nr);
    chk("tmo_cycle", 32'(rc), 32'd9);
    chk("tmo_is_err", 32'(re), 32'd1);
    chk("tmo_eaddr", 32'(err_addr), 32'h310020);
    chk("tmo_one_resp", 32'(nr), 32'd1);

    run_req(24'h400000, -1, 2, 10, rc, re, nr);
    chk("abort_resp", 32'(nr), 32'd0);
    run_req(24'h400002, -1, -1, 10, rc, re, nr);
    chk("after_abort_cycle", 32'(rc), 32'd7);
    chk("after_abort_din", 32'(cpu_din), 32'h5A5A);

    run_req(24'h080000, -1, -1, 12, rc, re, nr);
    chk("r3_cycle", 32'(rc), 32'd5);
    chk("r3_cs", 32'(cs_log[5]), 32'h8);
    chk("r3_one_resp", 32'(nr), 32'd1);

    @(posedge clk); #1;
    cpu_addr = 23'h200000; cpu_as = 1; cpu_uds = 1; cpu_lds = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("midrst_ack", 32'(cpu_bus_ack), 32'd0);
    chk("midrst_err", 32'(cpu_bus_err), 32'd0);
    chk("midrst_cs", 32'(slv_cs), 32'd0);
    chk("midrst_din", 32'(cpu_din), 32'd0);
    chk("midrst_eaddr", 32'(err_addr), 32'd0);
    @(posedge clk); #1;
    reset = 0; cpu_as = 0; cpu_uds = 0;
    repeat (8) @(posedge clk);
    #1;

    for (int n = 0; n < 2500; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (!cpu_as) begin
        if ($urandom_range(0, 2) == 0) begin
          a = pick_addr();
          cpu_addr = a[23:1];
          cpu_as = 1;
          cpu_uds = 1'($urandom_range(0, 1));
          cpu_lds = ($urandom_range(0, 3) != 0);
        end
      end else if ($urandom_range(0, 11) == 0) begin
        cpu_as = 0;
      end
      for (int b = 0; b < NS; b++) slv_ack[b] = ($urandom_range(0, 5) == 0);
      slv_dout = {$urandom(), $urandom()};
      cpu_write_strobe = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    reset = 0; cpu_as = 0; slv_ack = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/cdi_bus_fabric.md
# cdi_bus_fabric

Parametrised CPU-side bus fabric for the CD-i system top. It decodes the SCC68070 word address into up to NUM_SLAVES chip selects. Each region gets a fixed internal wait-state count or waits on an external slave acknowledge. The fabric multiplexes and registers read data, and generates bus error for unmapped addresses and for slaves that never acknowledge. It replaces the hand-written `always_comb` select/ack chain in the system top with one configurable block, adding timeout and abort handling.

## Interface
- NUM_SLAVES, 4, number of decoded regions (1..16)
- BASE, all zero, packed NUM_SLAVES×24-bit byte base addresses
- MASK, all zero, packed NUM_SLAVES×24-bit compare masks; a hit is `(addr_byte & MASK[i]) == BASE[i]`
- WAITS, all zero, packed NUM_SLAVES×4-bit wait counts; value 4'hF = WAIT_EXT (use slv_ack)
- TIMEOUT, 255, ACTIVE cycles before bus error (1..65535)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  23  word address addr[23:1]
- cpu_as  in  1  address strobe
- cpu_uds, cpu_lds  in  1 each  byte strobes
- cpu_write_strobe  in  1  write cycle (passed through unchanged to slaves, not used internally)
- cpu_din  out  16  read data to CPU, registered
- cpu_bus_ack  out  1  one-cycle transfer acknowledge
- cpu_bus_err  out  1  one-cycle bus error
- slv_cs  out  NUM_SLAVES  one-hot chip selects
- slv_ack  in  NUM_SLAVES  external acknowledges (sampled only for WAIT_EXT regions)
- slv_dout  in  NUM_SLAVES×16  slave read data, slave i at [16i+15:16i]
- err_addr  out  24  byte address of last bus error (debug)

## Operation
- Request: `cpu_as && (cpu_uds || cpu_lds)`.
- Decode: a priority match picks the lowest-index hitting region.
- States are IDLE, ACTIVE, ACK, ERR, DONE.
- IDLE:
  - On a request with a hit: latch sel, load wait counter with WAITS[sel], clear timeout counter, go to ACTIVE.
  - On a request with no hit: latch err_addr, go to ERR.
- ACTIVE:
  - slv_cs[sel]=1.
  - Internal region: when counter==0, go to ACK; otherwise decrement.
  - WAIT_EXT region: go to ACK when slv_ack[sel]=1.
  - Timeout counter increments every ACTIVE cycle. When it reaches TIMEOUT-1 without an ack, latch err_addr and go to ERR. An ack in that same cycle wins.
  - cpu_as low: abort to IDLE with no ack and no error.
- ACK:
  - cpu_bus_ack=1 and slv_cs[sel] remains 1.
  - cpu_din ← slv_dout[sel], captured on the ACTIVE→ACK edge. The value is held until the next capture.
  - Next state DONE.
- ERR: cpu_bus_err=1 for one cycle, slv_cs all 0, next state DONE.
- DONE: outputs idle; go to IDLE once cpu_as=0. This guarantees exactly one ack or error per strobe.
- Overlapping regions are legal; lower index has priority.

## Timing
- Reset values: state IDLE, cpu_din=0, cpu_bus_ack=0, cpu_bus_err=0, slv_cs=0, err_addr=0, counters 0. Reset asserted mid-transfer returns to IDLE immediately; no ack is issued afterwards.
- Cycle numbering: the request is seen in IDLE at cycle 0, and slv_cs rises at cycle 1.
- Internal region with WAITS=W: cpu_bus_ack in cycle W+2. For W=0 that is cycle 2.
- WAIT_EXT: slv_ack seen high in cycle k gives cpu_bus_ack in cycle k+1.
- Unmapped address: cpu_bus_err in cycle 1.
- Timeout: cpu_bus_err in cycle TIMEOUT+1.
- All outputs are registered. Nothing combinational from inputs to cpu_bus_ack, cpu_bus_err or cpu_din.

## Structure
- Package cdi_bus_pkg contains:
  - the state enum `bus_state_t` (IDLE, ACTIVE, ACK, ERR, DONE);
  - `WAIT_EXT = 4'hF`;
  - the default TIMEOUT localparam.
- Sub-module cdi_bus_match: parametrised combinational priority decoder. Inputs addr_byte, BASE, MASK. Outputs hit and sel index ($clog2(NUM_SLAVES) bits).
- Counters are sized with $clog2(TIMEOUT+1).

## Test plan
- NUM_SLAVES=2, region0 BASE 0x000000 MASK 0xF80000 WAITS 0; read 0x000010 with slv_dout0=0x1234 -> ack cycle 2, cpu_din=0x1234, slv_cs=2'b01 in cycles 1–2.
- Region1 BASE 0x310000 MASK 0xFF0000 WAIT_EXT; slv_ack1 raised at cycle 5 -> ack cycle 6, no error.
- Access 0x600000 (no hit) -> cpu_bus_err cycle 1, err_addr=0x600000, no slv_cs.
- WAIT_EXT region, slv_ack never asserted, TIMEOUT=8 -> cpu_bus_err cycle 9, err_addr latched.
- Abort and reset recovery:
  - cpu_as dropped in ACTIVE cycle 2 with WAITS 5 -> no ack and no error; next request acks normally.
  - reset pulsed mid-ACTIVE -> all outputs 0 and state IDLE.
- Overlapping regions 0 and 1 both hit -> slv_cs=2'b01; cpu_as held after ack -> exactly one ack, DONE until cpu_as falls.
